// File: rtl/alu_seq.sv
// Sequential 8-bit ALU: single-cycle logic/arith ops, iterative shift-left and shift-add
// multiply, with a start/busy/done handshake and registered result/flags.
module alu_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [2:0] OpAdd  = 3'b000;
    localparam logic [2:0] OpSub  = 3'b001;
    localparam logic [2:0] OpAnd  = 3'b010;
    localparam logic [2:0] OpOr   = 3'b011;
    localparam logic [2:0] OpXor  = 3'b100;
    localparam logic [2:0] OpShl  = 3'b101;
    localparam logic [2:0] OpMul  = 3'b110;
    localparam logic [2:0] OpPass = 3'b111;

    typedef enum logic {StIdle, StExec} state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_carry;
    logic               is_multi;
    logic               last_iter;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   sh_step;

    // Single-cycle result; SHL here only covers the zero-count case
    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} - {1'b0, b};
        sc_res   = b;
        sc_carry = 1'b0;
        case (op)
            OpAdd:   begin sc_res = sum[WIDTH-1:0];  sc_carry = sum[WIDTH];  end
            OpSub:   begin sc_res = diff[WIDTH-1:0]; sc_carry = diff[WIDTH]; end
            OpAnd:   sc_res = a & b;
            OpOr:    sc_res = a | b;
            OpXor:   sc_res = a ^ b;
            OpShl:   sc_res = a;
            OpPass:  sc_res = b;
            default: sc_res = b;
        endcase
    end

    assign is_multi  = (op == OpMul) || ((op == OpShl) && (b[SHW-1:0] != '0));
    assign last_iter = (cnt_q == CNTW'(1));
    assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign sh_step   = sh_q << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sh_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sh_q     <= sh_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start && is_multi) state_d = StExec;
            StExec:  if (last_iter) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sh_d     = sh_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d = op;
                    if (is_multi) begin
                        if (op == OpMul) begin
                            cnt_d    = CNTW'(WIDTH);
                            acc_d    = '0;
                            mcand_d  = {{WIDTH{1'b0}}, a};
                            mplier_d = b;
                        end else begin
                            cnt_d = CNTW'(b[SHW-1:0]);
                            sh_d  = a;
                        end
                    end else begin
                        result_d = sc_res;
                        carry_d  = sc_carry;
                        zero_d   = (sc_res == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            StExec: begin
                cnt_d = cnt_q - CNTW'(1);
                if (op_q == OpMul) begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end else begin
                    sh_d = sh_step;
                end
                if (last_iter) begin
                    done_d = 1'b1;
                    if (op_q == OpMul) begin
                        result_d = acc_step[WIDTH-1:0];
                        carry_d  = |acc_step[2*WIDTH-1:WIDTH];
                        zero_d   = (acc_step[WIDTH-1:0] == '0);
                    end else begin
                        // carry takes the bit leaving position WIDTH-1 on this final shift
                        result_d = sh_step;
                        carry_d  = sh_q[WIDTH-1];
                        zero_d   = (sh_step == '0);
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy   = (state_q == StExec);
        done   = done_q;
        result = result_q;
        zero   = zero_q;
        carry  = carry_q;
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table for every op, plus hand-written sequences
// for ignored start while busy, back-to-back issue and asynchronous reset mid-multiply.
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       zero;
    logic       carry;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         lat;
        logic [7:0] res;
        logic       c;
        logic       z;
    } vec_t;

    vec_t vecs[16];

    alu_seq #(.WIDTH(8), .CNTW(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero),
        .carry  (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one edge; returns at the falling edge after the start edge
    task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = 3'b000;
        a     = 8'h00;
        b     = 8'h00;
    endtask

    // Edges from the start edge until done, bounded; busy counted per sampled cycle
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int dcnt;
        int dedge;
        logic [7:0] dres;
        logic dcar;

        vecs[0]  = '{3'b000, 8'hF0, 8'h20, 1, 8'h10, 1'b1, 1'b0};
        vecs[1]  = '{3'b001, 8'h05, 8'h05, 1, 8'h00, 1'b0, 1'b1};
        vecs[2]  = '{3'b001, 8'h03, 8'h05, 1, 8'hFE, 1'b1, 1'b0};
        vecs[3]  = '{3'b010, 8'hF0, 8'h3C, 1, 8'h30, 1'b0, 1'b0};
        vecs[4]  = '{3'b011, 8'h0F, 8'h30, 1, 8'h3F, 1'b0, 1'b0};
        vecs[5]  = '{3'b100, 8'hAA, 8'hAA, 1, 8'h00, 1'b0, 1'b1};
        vecs[6]  = '{3'b111, 8'h11, 8'h5A, 1, 8'h5A, 1'b0, 1'b0};
        vecs[7]  = '{3'b110, 8'h0F, 8'h11, 9, 8'hFF, 1'b0, 1'b0};
        vecs[8]  = '{3'b110, 8'h10, 8'h10, 9, 8'h00, 1'b1, 1'b1};
        vecs[9]  = '{3'b110, 8'hFF, 8'hFF, 9, 8'h01, 1'b1, 1'b0};
        vecs[10] = '{3'b101, 8'h81, 8'h01, 2, 8'h02, 1'b1, 1'b0};
        vecs[11] = '{3'b101, 8'h81, 8'h00, 1, 8'h81, 1'b0, 1'b0};
        vecs[12] = '{3'b101, 8'h81, 8'h07, 8, 8'h80, 1'b0, 1'b0};
        vecs[13] = '{3'b101, 8'h40, 8'h02, 3, 8'h00, 1'b1, 1'b1};
        vecs[14] = '{3'b101, 8'h01, 8'h09, 2, 8'h02, 1'b0, 1'b0};
        vecs[15] = '{3'b000, 8'hFF, 8'h01, 1, 8'h00, 1'b1, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 3'b000;
        a     = 8'h00;
        b     = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_busy",   32'(busy),   32'h0);
        chk("reset_done",   32'(done),   32'h0);
        chk("reset_result", 32'(result), 32'h0);
        chk("reset_zero",   32'(zero),   32'h0);
        chk("reset_carry",  32'(carry),  32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, bcnt);
            chk($sformatf("v%0d_done", i),   32'(done),   32'h1);
            chk($sformatf("v%0d_lat", i),    32'(lat),    32'(vecs[i].lat));
            chk($sformatf("v%0d_busy", i),   32'(bcnt),   32'(vecs[i].lat - 1));
            chk($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
            chk($sformatf("v%0d_carry", i),  32'(carry),  32'(vecs[i].c));
            chk($sformatf("v%0d_zero", i),   32'(zero),   32'(vecs[i].z));
            @(negedge clk);
            chk($sformatf("v%0d_done_low", i), 32'(done), 32'h0);
            chk($sformatf("v%0d_hold", i),     32'(result), 32'(vecs[i].res));
        end

        // start while busy must be ignored: ADD 1+1 offered at cycle 3 of MUL 3*5
        issue(3'b110, 8'h03, 8'h05);
        @(negedge clk);
        start = 1'b1;
        op    = 3'b000;
        a     = 8'h01;
        b     = 8'h01;
        @(negedge clk);
        start = 1'b0;
        dcnt  = 0;
        dedge = 0;
        dres  = 8'h00;
        dcar  = 1'b1;
        for (int e = 4; e < 16; e++) begin
            @(negedge clk);
            if (done) begin
                dcnt++;
                if (dcnt == 1) begin
                    dedge = e;
                    dres  = result;
                    dcar  = carry;
                end
            end
        end
        chk("busy_start_dones",  32'(dcnt),  32'h1);
        chk("busy_start_edge",   32'(dedge), 32'd9);
        chk("busy_start_result", 32'(dres),  32'h0F);
        chk("busy_start_carry",  32'(dcar),  32'h0);
        chk("busy_start_final",  32'(result), 32'h0F);

        // start held high with a single-cycle op: done every cycle
        @(negedge clk);
        start = 1'b1;
        op    = 3'b000;
        a     = 8'h01;
        b     = 8'h01;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("b2b%0d_done", k),   32'(done),   32'h1);
            chk($sformatf("b2b%0d_result", k), 32'(result), 32'(k + 2));
            a = 8'(k + 2);
        end
        start = 1'b0;
        @(negedge clk);
        chk("b2b_done_low", 32'(done), 32'h0);

        // asynchronous reset in the middle of a multiply
        issue(3'b110, 8'h07, 8'h07);
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_busy",   32'(busy),   32'h0);
        chk("mid_reset_done",   32'(done),   32'h0);
        chk("mid_reset_result", 32'(result), 32'h0);
        chk("mid_reset_zero",   32'(zero),   32'h0);
        chk("mid_reset_carry",  32'(carry),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'b000, 8'h01, 8'h02);
        wait_done(lat, bcnt);
        chk("post_reset_lat",    32'(lat),    32'd1);
        chk("post_reset_done",   32'(done),   32'h1);
        chk("post_reset_result", 32'(result), 32'h03);
        chk("post_reset_carry",  32'(carry),  32'h0);
        repeat (12) @(negedge clk);
        chk("post_reset_quiet",  32'(done),   32'h0);
        chk("post_reset_idle",   32'(busy),   32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
